uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_frame_if.sv | 32 +++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx_frame.sv | 142 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the parity-mode encodings, the transmitter state enum and the smallest
// legal baud divisor. The Tx block uses it now, and the matching Rx is meant to
// reuse it.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Any requested divisor below this value is raised to it.
  localparam int MIN_BAUD_DIV = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_frame_if.sv
// Word-source handshake for uart_tx_frame.
// Signals:
//   i_valid    - the source has a word to send
//   o_ready    - the transmitter accepts a word this cycle
//   i_data     - the word to send (LSB goes out first)
//   i_baud_div - clk cycles per bit, sampled when the word is accepted
// The master modport is the byte source. The slave modport is the transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
);

  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DIV_WIDTH-1:0]  i_baud_div;

  modport master (
    output i_valid,
    output i_data,
    output i_baud_div,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_baud_div,
    output o_ready
  );

endinterface : uart_tx_frame_if

// File: rtl/uart_baud_gen.sv
// Restartable baud divider.
// The counter runs 0..div-1 and then wraps. bit_tick is high while the count
// equals div-1, so the tick marks the last clk cycle of each bit.
// Asserting restart holds the count at 0. The first bit after restart therefore
// lasts a full div cycles.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   restart    - hold the count at 0
//   div        - cycles per bit, already clamped to at least 2 by the caller
//   bit_tick   - last cycle of the current bit
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign bit_tick = (cnt_q == div - DIV_WIDTH'(1));

  // NOTE: registers are written with <= so that every flop in the design
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule : uart_baud_gen

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter.
// A frame is made of:
//   - a start bit (0);
//   - DATA_WIDTH data bits, LSB first;
//   - an optional parity bit;
//   - STOP_BITS stop bits (1).
// Each bit lasts D = max(i_baud_div, 2) clk cycles. The data word, the parity
// bit and D are all captured when the word is accepted, so later changes to the
// inputs do not affect the frame in flight.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   tx_if       - valid/ready word handshake plus the baud divisor (slave side)
//   o_busy      - a frame is in progress
//   o_done      - one-cycle pulse in the first idle cycle after a frame
//   serial_out  - serial line, high when idle
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int DIV_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_frame_if.slave   tx_if,
  output logic             o_busy,
  output logic             o_done,
  output logic             serial_out
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH must be 5..9");
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parity_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  done_q;
  logic                  bit_tick;
  logic                  accept;
  logic                  last_data;
  logic                  last_stop;
  logic [DIV_WIDTH-1:0]  div_eff;

  assign tx_if.o_ready = (state_q == IDLE) && !reset;
  assign accept        = tx_if.i_valid && tx_if.o_ready;
  assign last_data     = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign last_stop     = (bit_cnt_q == CNT_W'(STOP_BITS - 1));
  assign div_eff       = (tx_if.i_baud_div < DIV_WIDTH'(MIN_BAUD_DIV)) ?
                         DIV_WIDTH'(MIN_BAUD_DIV) : tx_if.i_baud_div;

  // The divider is held at 0 in IDLE, so its count starts at 0 in the first
  // START cycle.
  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .restart  (state_q == IDLE),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (bit_tick) state_d = DATA;
      DATA:   if (bit_tick && last_data)
                state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY: if (bit_tick) state_d = STOP;
      STOP:   if (bit_tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      div_q     <= DIV_WIDTH'(MIN_BAUD_DIV);
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == STOP) && bit_tick && last_stop;
      if (accept) begin
        shift_q   <= tx_if.i_data;
        parity_q  <= (PARITY_MODE == PARITY_ODD) ? ~^tx_if.i_data : ^tx_if.i_data;
        div_q     <= div_eff;
        bit_cnt_q <= '0;
      end else if (bit_tick) begin
        // The bit counter is reused: it counts data bits in DATA and stop bits
        // in STOP, and it is back at 0 whenever either phase ends.
        unique case (state_q)
          DATA: begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= last_data ? '0 : bit_cnt_q + CNT_W'(1);
          end
          STOP:    bit_cnt_q <= last_stop ? '0 : bit_cnt_q + CNT_W'(1);
          default: bit_cnt_q <= '0;
        endcase
      end
    end
  end

  // The line level is decoded from registered state only. Reset forces
  // IDLE, so the line returns high one cycle after reset is asserted.
  always_comb begin
    serial_out = 1'b1;
    unique case (state_q)
      START:   serial_out = 1'b0;
      DATA:    serial_out = shift_q[0];
      PARITY:  serial_out = parity_q;
      default: serial_out = 1'b1;
    endcase
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame. Three instances share clk, reset and the
// data/divisor stimulus:
//   sel 0 - 8E1
//   sel 1 - 8O1
//   sel 2 - 8N2
// Only the selected instance sees i_valid.
// Each expected frame is written as a string of line levels, one character per
// bit in transmit order. Each bit must hold for bit_cycles clk cycles, and
// o_done must appear in the cycle right after the last one.
module tb_uart_tx_frame;

  typedef enum {P_NONE, P_DIV, P_PULSE, P_ABORT} poke_e;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [15:0] div;
    int          bit_cycles;
    string       frame;
    poke_e       poke;
    int          poke_cyc;
    logic [15:0] poke_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [7:0]  data;
  logic [15:0] div;
  int          sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic so_e, so_o, so_n;
  logic busy_e, busy_o, busy_n;
  logic done_e, done_o, done_n;
  logic s_out, s_busy, s_done, s_ready;

  uart_tx_frame_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) if_e ();
  uart_tx_frame_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) if_o ();
  uart_tx_frame_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) if_n ();

  assign if_e.i_valid = valid && (sel == 0);
  assign if_o.i_valid = valid && (sel == 1);
  assign if_n.i_valid = valid && (sel == 2);
  assign if_e.i_data = data;
  assign if_o.i_data = data;
  assign if_n.i_data = data;
  assign if_e.i_baud_div = div;
  assign if_o.i_baud_div = div;
  assign if_n.i_baud_div = div;

  uart_tx_frame #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .DIV_WIDTH(16)) dut_e (
    .clk(clk), .reset(reset), .tx_if(if_e), .o_busy(busy_e), .o_done(done_e), .serial_out(so_e));
  uart_tx_frame #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .DIV_WIDTH(16)) dut_o (
    .clk(clk), .reset(reset), .tx_if(if_o), .o_busy(busy_o), .o_done(done_o), .serial_out(so_o));
  uart_tx_frame #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(2), .DIV_WIDTH(16)) dut_n (
    .clk(clk), .reset(reset), .tx_if(if_n), .o_busy(busy_n), .o_done(done_n), .serial_out(so_n));

  always #5 clk = ~clk;

  always_comb begin
    s_out = so_e; s_busy = busy_e; s_done = done_e; s_ready = if_e.o_ready;
    if (sel == 1) begin
      s_out = so_o; s_busy = busy_o; s_done = done_o; s_ready = if_o.o_ready;
    end else if (sel == 2) begin
      s_out = so_n; s_busy = busy_n; s_done = done_n; s_ready = if_n.o_ready;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk_vec(int s, logic [7:0] d, logic [15:0] bd, int bc, string fr,
                                  poke_e pk, int pc, logic [15:0] pv);
    vec_t v;
    v.sel = s; v.data = d; v.div = bd; v.bit_cycles = bc; v.frame = fr;
    v.poke = pk; v.poke_cyc = pc; v.poke_val = pv;
    return v;
  endfunction

  // Called at a negedge. The word is accepted at the following posedge.
  // With hold set, i_valid stays high and i_data moves on to next_data.
  task automatic send(input int s, input logic [7:0] d, input logic [15:0] bd,
                      input bit hold, input logic [7:0] next_data);
    sel = s; data = d; div = bd; valid = 1'b1;
    #1;
    check($sformatf("ready before accept sel%0d", s), s_ready, 1);
    @(posedge clk);
    #1;
    if (hold) data = next_data;
    else valid = 1'b0;
  endtask

  // Called just after the accept edge. Returns at the negedge of the o_done
  // cycle, or right after reset is raised when the frame is aborted.
  task automatic expect_frame(input string tag, input string frame, input int bc,
                              input poke_e poke, input int poke_cyc, input logic [15:0] poke_val);
    int len;
    len = frame.len() * bc;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      check($sformatf("%s serial cyc %0d", tag, c), s_out, (frame.getc(c / bc) == 8'h31));
      check($sformatf("%s done cyc %0d", tag, c), s_done, 0);
      if (c % bc == 0) begin
        check($sformatf("%s busy cyc %0d", tag, c), s_busy, 1);
        check($sformatf("%s ready cyc %0d", tag, c), s_ready, 0);
      end
      if (poke == P_ABORT && c == poke_cyc) begin
        reset = 1'b1;
        return;
      end
      if (poke == P_DIV && c == poke_cyc) div = poke_val;
      if (poke == P_PULSE && c == poke_cyc) begin
        valid = 1'b1;
        data  = poke_val[7:0];
      end
      if (poke == P_PULSE && c == poke_cyc + 1) begin
        valid = 1'b0;
        data  = 8'hFF;
      end
    end
    @(negedge clk);
    check({tag, " done pulse"}, s_done, 1);
    check({tag, " busy at done"}, s_busy, 0);
    check({tag, " ready at done"}, s_ready, 1);
    check({tag, " serial at done"}, s_out, 1);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; data = '0; div = 16'd4; sel = 0;

    // Expected line levels: start, data LSB first, parity (if any), stop(s).
    vecs[0] = mk_vec(0, 8'hA5, 16'd4, 4, "01010010101", P_NONE, 0, 16'd0);  // 8E1 D=4
    vecs[1] = mk_vec(1, 8'h07, 16'd3, 3, "01110000001", P_NONE, 0, 16'd0);  // 8O1, parity 0
    vecs[2] = mk_vec(0, 8'h07, 16'd3, 3, "01110000011", P_NONE, 0, 16'd0);  // 8E1, parity 1
    vecs[3] = mk_vec(0, 8'h81, 16'd0, 2, "01000000101", P_NONE, 0, 16'd0);  // div 0 -> 2
    vecs[4] = mk_vec(0, 8'h5A, 16'd1, 2, "00101101001", P_NONE, 0, 16'd0);  // div 1 -> 2
    vecs[5] = mk_vec(0, 8'hC3, 16'd4, 4, "01100001101", P_DIV, 10, 16'd8);  // div 4->8 mid-frame
    vecs[6] = mk_vec(0, 8'h12, 16'd8, 8, "00100100001", P_NONE, 0, 16'd0);  // next frame at 8
    vecs[7] = mk_vec(1, 8'h0F, 16'd3, 3, "01111000011", P_PULSE, 7, 16'h55); // valid pulse while busy

    // Reset state
    repeat (2) @(negedge clk);
    check("reset ready e", if_e.o_ready, 0);
    check("reset ready o", if_o.o_ready, 0);
    check("reset ready n", if_n.o_ready, 0);
    check("reset serial e", so_e, 1);
    check("reset serial n", so_n, 1);
    check("reset busy e", busy_e, 0);
    check("reset done e", done_e, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset ready e", if_e.o_ready, 1);
    check("post-reset ready o", if_o.o_ready, 1);
    check("post-reset ready n", if_n.o_ready, 1);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].div, 1'b0, 8'h00);
      expect_frame($sformatf("v%0d", i), vecs[i].frame, vecs[i].bit_cycles,
                   vecs[i].poke, vecs[i].poke_cyc, vecs[i].poke_val);
      @(negedge clk);
      check($sformatf("v%0d done cleared", i), s_done, 0);
      check($sformatf("v%0d idle after", i), s_busy, 0);
    end

    // Back-to-back 8N2 D=5. i_valid stays high, and the second word is taken in
    // the o_done cycle.
    @(negedge clk);
    send(2, 8'h00, 16'd5, 1'b1, 8'hFF);
    expect_frame("b2b frame1", "00000000011", 5, P_NONE, 0, 16'd0);
    @(posedge clk);
    #1 valid = 1'b0;
    expect_frame("b2b frame2", "01111111111", 5, P_NONE, 0, 16'd0);
    @(negedge clk);
    check("b2b done cleared", s_done, 0);

    // Reset during data bit 3 (cycles 16..19 of the frame) at D=4
    @(negedge clk);
    send(0, 8'h3C, 16'd4, 1'b0, 8'h00);
    expect_frame("abort", "00011110001", 4, P_ABORT, 17, 16'd0);
    @(negedge clk);
    check("abort serial", s_out, 1);
    check("abort busy", s_busy, 0);
    check("abort done", s_done, 0);
    check("abort ready in reset", s_ready, 0);
    @(negedge clk);
    check("abort done hold", s_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort ready after reset", s_ready, 1);
    check("abort no done", s_done, 0);
    send(0, 8'h81, 16'd4, 1'b0, 8'h00);
    expect_frame("after abort", "01000000101", 4, P_NONE, 0, 16'd0);
    @(negedge clk);
    check("after abort done cleared", s_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_frame
